uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 130 +++++++++++++
 tb/tb_uart_receiver.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled 8-bit UART receiver with optional parity and stop-bit checking.
// Bits are sampled mid-period from a synchronized copy of the line.
module uart_receiver #(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clk_tick,
   input  logic       i_rx,
   input  logic       parity_en,
   input  logic       parity_odd,
   output logic [7:0] o_data_byte,
   output logic       o_data_valid,
   output logic       o_active,
   output logic       o_parity_err,
   output logic       o_frame_err
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] vld_q;
   logic                   armed_q;
   logic                   prev_q;
   logic [CW-1:0]          cnt_q;
   logic [2:0]             idx_q;
   logic [7:0]             shift_q;
   logic                   pbit_q;
   logic                   pen_q;
   logic                   podd_q;
   logic [7:0]             data_q;
   logic                   valid_q;
   logic                   active_q;
   logic                   perr_q;
   logic                   ferr_q;

   logic          rx_s;
   logic          end_tick;
   logic [7:0]    shift_d;
   logic          perr_d;
   logic [CW-1:0] cnt_d;

   assign rx_s     = sync_q[SYNC_STAGES-1];
   assign end_tick = clk_tick && (cnt_q == ((state_q == START) ? HALF_M1 : FULL_M1));
   assign cnt_d    = end_tick ? '0 : cnt_q + CW'(1);
   assign shift_d  = {rx_s, shift_q[7:1]};
   assign perr_d   = pen_q && ((^shift_q ^ pbit_q) != podd_q);

   // armed_q blocks the artificial 1->0 seen when a low line flushes the reset-high synchronizer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sync_q   <= '1;
         vld_q    <= '0;
         armed_q  <= 1'b0;
         prev_q   <= 1'b1;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         pbit_q   <= 1'b0;
         pen_q    <= 1'b0;
         podd_q   <= 1'b0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         active_q <= 1'b0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         sync_q[0] <= i_rx;
         vld_q[0]  <= 1'b1;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
            vld_q[k]  <= vld_q[k-1];
         end
         if (vld_q[SYNC_STAGES-1] && rx_s) armed_q <= 1'b1;
         prev_q  <= rx_s;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         if (clk_tick && state_q != IDLE && state_q != WAIT_IDLE) cnt_q <= cnt_d;
         case (state_q)
            IDLE: if (armed_q && prev_q && !rx_s) begin
               state_q  <= START;
               cnt_q    <= '0;
               active_q <= 1'b1;
               pen_q    <= parity_en;
               podd_q   <= parity_odd;
            end
            START: if (end_tick) begin
               state_q  <= rx_s ? IDLE : DATA;
               active_q <= !rx_s;
               idx_q    <= '0;
            end
            DATA: if (end_tick) begin
               shift_q <= shift_d;
               idx_q   <= idx_q + 3'd1;
               if (idx_q == 3'd7) state_q <= pen_q ? PARITY : STOP;
            end
            PARITY: if (end_tick) begin
               pbit_q  <= rx_s;
               state_q <= STOP;
            end
            STOP: if (end_tick) begin
               valid_q  <= 1'b1;
               data_q   <= shift_q;
               perr_q   <= perr_d;
               ferr_q   <= !rx_s;
               state_q  <= rx_s ? IDLE : WAIT_IDLE;
               active_q <= !rx_s;
            end
            WAIT_IDLE: if (rx_s) begin
               state_q  <= IDLE;
               active_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_data_byte  = data_q;
   assign o_data_valid = valid_q;
   assign o_active     = active_q;
   assign o_parity_err = perr_q;
   assign o_frame_err  = ferr_q;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized and directed frames checked against a frame-level reference model.
module tb_uart_receiver;
   localparam int OS = 16;

   logic       clk = 1'b0, rst_n = 1'b0, clk_tick = 1'b0, i_rx = 1'b1;
   logic       parity_en = 1'b0, parity_odd = 1'b0;
   logic [7:0] o_data_byte;
   logic       o_data_valid, o_active, o_parity_err, o_frame_err;

   int         n_checks = 0, n_fail = 0;
   logic [9:0] got[$];
   logic       active_seen = 1'b0;
   logic       prev_valid = 1'b0;

   uart_receiver #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .clk_tick(clk_tick), .i_rx(i_rx),
      .parity_en(parity_en), .parity_odd(parity_odd),
      .o_data_byte(o_data_byte), .o_data_valid(o_data_valid), .o_active(o_active),
      .o_parity_err(o_parity_err), .o_frame_err(o_frame_err)
   );

   always #5 clk = ~clk;

   initial begin : tick_gen
      int c;
      c = 0;
      forever begin
         @(negedge clk);
         clk_tick = (c == 0);
         c = (c == 2) ? 0 : c + 1;
      end
   end

   always @(negedge clk) begin
      if (o_data_valid) got.push_back({o_frame_err, o_parity_err, o_data_byte});
      if (o_active) active_seen = 1'b1;
      n_checks++;
      if (!o_data_valid && (o_parity_err || o_frame_err)) begin
         n_fail++;
         $display("FAIL flags_unqualified: perr=%b ferr=%b, required 0 while valid low", o_parity_err, o_frame_err);
      end
      n_checks++;
      if (prev_valid && o_data_valid) begin
         n_fail++;
         $display("FAIL valid_width: valid high 2 cycles, required 1-cycle pulse");
      end
      prev_valid = o_data_valid;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   // {frame_err, parity_err, byte} expected for one frame
   function automatic logic [9:0] model(input logic [7:0] d, input logic pen, input logic podd,
                                        input logic pbit, input logic stop);
      int ones;
      ones = $countones(d) + int'(pbit);
      return {!stop, pen && (logic'(ones % 2) != podd), d};
   endfunction

   task automatic tick_wait(input int n);
      repeat (n) begin
         do @(posedge clk); while (!clk_tick);
      end
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                             input logic pbit, input logic stop, input logic scramble);
      parity_en  = pen;
      parity_odd = podd;
      i_rx = 1'b0;
      tick_wait(OS);
      if (scramble) begin
         parity_en  = 1'($urandom);
         parity_odd = 1'($urandom);
      end
      for (int i = 0; i < 8; i++) begin
         i_rx = d[i];
         tick_wait(OS);
      end
      if (pen) begin
         i_rx = pbit;
         tick_wait(OS);
      end
      i_rx = stop;
      tick_wait(OS);
   endtask

   task automatic test_reset;
      i_rx = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({o_data_byte, o_data_valid, o_active, o_parity_err, o_frame_err} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_outputs: got byte=%h v=%b a=%b pe=%b fe=%b, required all 0",
                  o_data_byte, o_data_valid, o_active, o_parity_err, o_frame_err);
      end
      rst_n = 1'b1;
      got.delete();
      active_seen = 1'b0;
      tick_wait(40);
      n_checks++;
      if (active_seen !== 1'b0 || got.size() != 0) begin
         n_fail++;
         $display("FAIL low_at_release: active_seen=%b frames=%0d, required 0 and 0", active_seen, got.size());
      end
      i_rx = 1'b1;
      tick_wait(4);
   endtask

   task automatic test_basic;
      got.delete();
      active_seen = 1'b0;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick_wait(2);
      n_checks++;
      if (got.size() != 1) begin
         n_fail++;
         $display("FAIL basic_count: got %0d frames, required 1", got.size());
      end else begin
         n_checks++;
         if (got[0] !== model(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL basic_frame: got %h, required %h", got[0], model(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1));
         end
      end
      n_checks++;
      if (o_active !== 1'b0 || active_seen !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_active: active=%b seen=%b, required 0 and 1", o_active, active_seen);
      end
   endtask

   task automatic test_parity;
      logic [9:0] exp;
      for (int p = 1; p >= 0; p--) begin
         got.delete();
         send_frame(8'h07, 1'b1, 1'b0, 1'(p), 1'b1, 1'b0);
         exp = model(8'h07, 1'b1, 1'b0, 1'(p), 1'b1);
         n_checks++;
         if (got.size() != 1 || got[0] !== exp) begin
            n_fail++;
            $display("FAIL parity_even_pbit%0d: got %0d frames first=%h, required 1 frame %h",
                     p, got.size(), got.size() > 0 ? got[0] : 10'h0, exp);
         end
      end
   endtask

   task automatic test_frame_err;
      got.delete();
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (got.size() != 1 || got[0] !== model(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0)) begin
         n_fail++;
         $display("FAIL frame_err: got %0d frames first=%h, required 1 frame %h",
                  got.size(), got.size() > 0 ? got[0] : 10'h0, model(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      tick_wait(20);
      n_checks++;
      if (o_active !== 1'b1) begin
         n_fail++;
         $display("FAIL wait_idle_hold: active=%b, required 1 while line low", o_active);
      end
      i_rx = 1'b1;
      tick_wait(4);
      n_checks++;
      if (o_active !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_idle_exit: active=%b, required 0", o_active);
      end
      got.delete();
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (got.size() != 1 || got[0] !== model(8'h81, 1'b0, 1'b0, 1'b0, 1'b1)) begin
         n_fail++;
         $display("FAIL after_frame_err: got %0d frames first=%h, required 1 frame %h",
                  got.size(), got.size() > 0 ? got[0] : 10'h0, model(8'h81, 1'b0, 1'b0, 1'b0, 1'b1));
      end
   endtask

   task automatic test_glitch;
      got.delete();
      i_rx = 1'b0;
      tick_wait(3);
      n_checks++;
      if (o_active !== 1'b1) begin
         n_fail++;
         $display("FAIL glitch_active: active=%b, required 1 after start edge", o_active);
      end
      tick_wait(1);
      i_rx = 1'b1;
      tick_wait(12);
      n_checks++;
      if (o_active !== 1'b0 || got.size() != 0) begin
         n_fail++;
         $display("FAIL glitch_reject: active=%b frames=%0d, required 0 and 0", o_active, got.size());
      end
   endtask

   task automatic test_reset_midframe;
      logic [7:0] d;
      d = 8'hC3;
      got.delete();
      parity_en = 1'b0;
      i_rx = 1'b0;
      tick_wait(OS);
      for (int i = 0; i < 3; i++) begin
         i_rx = d[i];
         tick_wait(OS);
      end
      i_rx = d[3];
      tick_wait(OS / 2);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({o_data_byte, o_data_valid, o_active, o_parity_err, o_frame_err} !== 12'h000) begin
         n_fail++;
         $display("FAIL midframe_reset: got byte=%h v=%b a=%b pe=%b fe=%b, required all 0",
                  o_data_byte, o_data_valid, o_active, o_parity_err, o_frame_err);
      end
      i_rx = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick_wait(4 * OS);
      n_checks++;
      if (got.size() != 0 || o_active !== 1'b0) begin
         n_fail++;
         $display("FAIL midframe_abandon: frames=%0d active=%b, required 0 and 0", got.size(), o_active);
      end
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (got.size() != 1 || got[0] !== model(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1)) begin
         n_fail++;
         $display("FAIL after_reset_frame: got %0d frames first=%h, required 1 frame %h",
                  got.size(), got.size() > 0 ? got[0] : 10'h0, model(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1));
      end
   endtask

   task automatic test_back_to_back;
      got.delete();
      send_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      tick_wait(2);
      n_checks++;
      if (got.size() != 2) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d frames, required 2", got.size());
      end else begin
         n_checks++;
         if (got[0] !== model(8'h00, 1'b1, 1'b1, 1'b1, 1'b1) || got[1] !== model(8'hFF, 1'b1, 1'b1, 1'b1, 1'b1)) begin
            n_fail++;
            $display("FAIL b2b_frames: got %h %h, required %h %h", got[0], got[1],
                     model(8'h00, 1'b1, 1'b1, 1'b1, 1'b1), model(8'hFF, 1'b1, 1'b1, 1'b1, 1'b1));
         end
      end
   endtask

   task automatic test_random;
      logic [7:0] d;
      logic       pen, podd, pbit, stop;
      logic [9:0] exp;
      for (int n = 0; n < 24; n++) begin
         d    = 8'($urandom);
         pen  = 1'($urandom);
         podd = 1'($urandom);
         pbit = pen ? 1'($urandom) : 1'b0;
         stop = ($urandom_range(0, 3) != 0);
         exp  = model(d, pen, podd, pbit, stop);
         got.delete();
         send_frame(d, pen, podd, pbit, stop, 1'b1);
         n_checks++;
         if (got.size() != 1 || got[0] !== exp) begin
            n_fail++;
            $display("FAIL random_%0d: got %0d frames first=%h, required 1 frame %h",
                     n, got.size(), got.size() > 0 ? got[0] : 10'h0, exp);
         end
         if (!stop) begin
            i_rx = 1'b1;
            tick_wait(3);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_frame_err();
      test_glitch();
      test_reset_midframe();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
